// File: rtl/mcu_pwm_gen.sv
// mcu_pwm_gen: tick-based PWM line generator with double-buffered period/duty.
// New settings take effect only at period boundaries, on entry to RUN, or on ticks when the period is 0.
module mcu_pwm_gen #(
    parameter int TICK_DIV = 200,
    parameter int WIDTH    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] period_in,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             load,
    output logic             pwm_out,
    output logic             period_done,
    output logic             pending
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [15:0] PRE_MAX = 16'(TICK_DIV - 1);
    state_t           state, state_nx;
    logic [15:0]      pre, pre_nx;
    logic [WIDTH-1:0] tick_cnt, tick_cnt_nx, act_period, act_period_nx, act_duty, act_duty_nx;
    logic [WIDTH-1:0] pend_period, pend_period_nx, pend_duty, pend_duty_nx;
    logic             pwm_nx, done_nx, pending_nx, running, tick, boundary, apply;

    always_comb begin
        running        = state == RUN && enable;
        tick           = state == RUN && pre == PRE_MAX;
        boundary       = tick && act_period != '0 && tick_cnt == act_period - WIDTH'(1);
        // Apply points: entering RUN, a period boundary, or any tick while the period is 0
        apply          = (state == IDLE && enable) || (running && (act_period == '0 ? tick : boundary));
        state_nx       = enable ? RUN : IDLE;
        pre_nx         = running && !tick ? pre + 16'd1 : '0;
        tick_cnt_nx    = !running || boundary || act_period == '0 ? '0 : tick ? tick_cnt + WIDTH'(1) : tick_cnt;
        pwm_nx         = running && act_period != '0 && tick_cnt < act_duty;
        done_nx        = running && boundary;
        act_period_nx  = act_period;
        act_duty_nx    = act_duty;
        pend_period_nx = pend_period;
        pend_duty_nx   = pend_duty;
        pending_nx     = pending;
        if (apply) begin
            act_period_nx = load ? period_in : pending ? pend_period : act_period;
            act_duty_nx   = load ? duty_in : pending ? pend_duty : act_duty;
            pending_nx    = 1'b0;
        end else if (load) begin
            pend_period_nx = period_in;
            pend_duty_nx   = duty_in;
            pending_nx     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pre         <= '0;
            tick_cnt    <= '0;
            act_period  <= '0;
            act_duty    <= '0;
            pend_period <= '0;
            pend_duty   <= '0;
            pending     <= 1'b0;
            pwm_out     <= 1'b0;
            period_done <= 1'b0;
        end else begin
            state       <= state_nx;
            pre         <= pre_nx;
            tick_cnt    <= tick_cnt_nx;
            act_period  <= act_period_nx;
            act_duty    <= act_duty_nx;
            pend_period <= pend_period_nx;
            pend_duty   <= pend_duty_nx;
            pending     <= pending_nx;
            pwm_out     <= pwm_nx;
            period_done <= done_nx;
        end
    end
endmodule
